// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and helpers for the APB requester arbiter.
// State encoding of the transfer sequencer and the timeout counter sizing rule.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Counter must hold TIMEOUT itself; a zero TIMEOUT still needs a 1-bit vector.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Round-robin pick among NREQ requests; combinational grant, 0-cycle latency.
// Pointer advances only when the caller accepts the grant, so pending requests never lose their turn.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                                      pclk,
  input  logic                                      presetn,
  input  logic [NREQ-1:0]                           req,
  input  logic                                      advance,
  output logic [NREQ-1:0]                           gnt_onehot,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_idx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] r_last;
  logic          w_hi_found;
  logic          w_lo_found;
  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;

  // Lowest set bit above the last grant wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IW'(i);
        if (i > int'(r_last)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IW'(i);
        end
      end
    end
  end

  assign gnt_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
  assign gnt_onehot = w_lo_found ? (NREQ'(1) << gnt_idx) : '0;

  // Reset value NREQ-1 makes requester 0 the first winner.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last <= IW'(NREQ - 1);
    end else if (advance && w_lo_found) begin
      r_last <= gnt_idx;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// APB master shared by NREQ requesters: accept at T, psel T+1, penable T+2, response >= T+3.
// Requests are held off (req_ready low) for the whole transfer; a pready timeout ends hung transfers.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW  = cnt_width(TIMEOUT);

  state_e          r_state;
  logic [IW-1:0]   r_gnt_idx;
  logic [CNTW-1:0] r_cnt;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;

  logic [NREQ-1:0] w_gnt_onehot;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_accept;
  logic            w_timeout;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  // Gated by presetn so req_ready is also low while reset is held.
  assign w_accept  = (r_state == IDLE) && (|req_valid) && presetn;
  assign req_ready = w_accept ? w_gnt_onehot : '0;

  assign w_sel_addr  = req_addr[w_gnt_idx*AW +: AW];
  assign w_sel_wdata = req_wdata[w_gnt_idx*DW +: DW];

  // pready on the final counted cycle takes priority over the timeout.
  assign w_timeout = (TIMEOUT > 0) && !pready && (r_cnt == CNTW'(TIMEOUT));

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .pclk       (pclk),
    .presetn    (presetn),
    .req        (req_valid),
    .advance    (w_accept),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_gnt_idx   <= '0;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_gnt_idx <= w_gnt_idx;
            r_pwrite  <= req_write[w_gnt_idx];
            r_paddr   <= w_sel_addr;
            r_pwdata  <= w_sel_wdata;
            r_psel    <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= CNTW'(1);
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_rsp_valid <= NREQ'(1) << r_gnt_idx;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_rsp_valid <= NREQ'(1) << r_gnt_idx;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed plus randomized bench for apb_req_arbiter with an APB register-file slave.
// Expected grants, timing and read data come from a round-robin/memory model kept here.
module tb_apb_req_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int TO   = 4;

  logic               pclk = 1'b0;
  logic               presetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready;

  int n_cmp = 0;
  int n_bad = 0;
  int m_last;
  logic [DW-1:0] emem [4];
  logic [DW-1:0] smem [4] = '{8'h00, 8'h3C, 8'h5A, 8'hC3};

  always #5 pclk = ~pclk;

  assign prdata = smem[paddr];
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) smem[paddr] <= pwdata;
  end

  apb_req_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_cmd(input int i);
    set_cmd(i, 1'($urandom % 2), AW'($urandom), DW'($urandom));
  endtask

  // Entered in the accept cycle; leaves in the response cycle (which may itself accept the next request).
  // keep: 0 drop request, 1 hold same command, 2 hold with a new command.
  task automatic xfer(input int nwait, input int keep, input bit pulse1);
    int            who;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            to;
    logic [DW-1:0] exp_rd;
    who = rr_pick(req_valid, m_last);
    chk("accept_ready", req_ready, (who < 0) ? 0 : (1 << who));
    if (who < 0) return;
    m_last = who;
    w  = req_write[who];
    a  = req_addr[who*AW +: AW];
    d  = req_wdata[who*DW +: DW];
    to = (nwait >= TO);

    @(negedge pclk);
    if (keep == 0) req_valid[who] = 1'b0;
    else if (keep == 2) rand_cmd(who);
    #1;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, d);
    chk("setup_ready", req_ready, 0);
    chk("setup_rsp", rsp_valid, 0);

    for (int k = 0; k < TO; k++) begin
      @(negedge pclk);
      pready = (k >= nwait);
      if (pulse1) req_valid[1] = (k == 0);
      #1;
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwrite", pwrite, w);
      chk("access_pwdata", pwdata, d);
      chk("access_ready", req_ready, 0);
      chk("access_rsp", rsp_valid, 0);
      if (pready) break;
    end

    @(negedge pclk);
    pready = 1'b0;
    #1;
    exp_rd = (to || w) ? '0 : emem[a];
    chk("rsp_valid", rsp_valid, 1 << who);
    chk("rsp_err", rsp_err, to);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel", psel, 0);
    chk("rsp_penable", penable, 0);
    if (!to && w) emem[a] = d;
  endtask

  initial begin
    presetn   = 1'b0;
    pready    = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_last    = NREQ - 1;
    emem      = '{8'h00, 8'h3C, 8'h5A, 8'hC3};

    // Reset: all outputs low even with requests present
    @(negedge pclk);
    req_valid = '1;
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge pclk);
    req_valid = '0;
    presetn   = 1'b1;
    #1;
    chk("idle_psel", psel, 0);

    // Both requesters reading continuously: grants 0,1,0,1 with own data
    @(negedge pclk);
    set_cmd(0, 1'b0, 2'd1, 8'h00);
    set_cmd(1, 1'b0, 2'd3, 8'h00);
    req_valid = 2'b11;
    #1;
    xfer(0, 1, 0);
    xfer(0, 1, 0);
    xfer(0, 0, 0);
    xfer(0, 0, 0);

    // Zero-wait write from requester 0
    @(negedge pclk);
    set_cmd(0, 1'b1, 2'd2, 8'hA5);
    req_valid = 2'b01;
    #1;
    xfer(0, 0, 0);

    // Three wait states, pready on the last counted cycle; reads back the write above
    @(negedge pclk);
    set_cmd(1, 1'b0, 2'd2, 8'h00);
    req_valid = 2'b10;
    #1;
    xfer(3, 0, 0);

    // Hung slave: write and read both time out
    @(negedge pclk);
    set_cmd(0, 1'b1, 2'd3, 8'h99);
    req_valid = 2'b01;
    #1;
    xfer(9, 0, 0);
    @(negedge pclk);
    set_cmd(1, 1'b0, 2'd1, 8'h00);
    req_valid = 2'b10;
    #1;
    xfer(4, 0, 0);

    // req1 pulsed during req0 ACCESS is never accepted
    @(negedge pclk);
    set_cmd(0, 1'b0, 2'd0, 8'h00);
    req_valid = 2'b01;
    #1;
    xfer(2, 0, 1);
    chk("pulse_no_ready", req_ready, 0);
    @(negedge pclk);
    #1;
    chk("pulse_no_xfer", psel, 0);

    // Reset during ACCESS aborts the transfer without a response
    @(negedge pclk);
    set_cmd(0, 1'b1, 2'd0, 8'h42);
    req_valid = 2'b01;
    #1;
    chk("abort_ready", req_ready, 2'b01);
    @(negedge pclk);
    req_valid = '0;
    #1;
    chk("abort_setup", psel, 1);
    @(negedge pclk);
    #1;
    chk("abort_access", penable, 1);
    #2;
    presetn = 1'b0;
    #1;
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    req_valid = 2'b11;
    m_last    = NREQ - 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk);
      #1;
      chk("abort_rsp", rsp_valid, 0);
      chk("abort_hold_ready", req_ready, 0);
      chk("abort_hold_psel", psel, 0);
    end
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    chk("release_rsp", rsp_valid, 0);
    xfer(0, 0, 0);
    xfer(1, 0, 0);

    // Randomized traffic against the round-robin/memory model
    for (int it = 0; it < 40; it++) begin
      if (req_valid == '0) begin
        @(negedge pclk);
        for (int i = 0; i < NREQ; i++) rand_cmd(i);
        req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        #1;
      end
      xfer($urandom_range(0, 5), $urandom_range(0, 2), 0);
    end
    for (int g = 0; g < NREQ; g++) begin
      if (req_valid != '0) xfer(0, 0, 0);
    end
    @(negedge pclk);
    #1;
    chk("final_psel", psel, 0);
    chk("final_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
